// File: rtl/bram_wr_arbiter_pkg.sv
// Shared types and address helpers for the BRAM write arbiter.
// Pure declarations: no latency, no backpressure.
package bram_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam logic [3:0] WE_ALL         = 4'hF;
    localparam int         BYTES_PER_WORD = 4;

    // Byte address of the first word owned by requester `id`.
    function automatic logic [31:0] region_base(input logic [31:0] base,
                                                input logic [31:0] id,
                                                input int unsigned words);
        return base + id * 32'(words) * 32'(BYTES_PER_WORD);
    endfunction

endpackage

// File: rtl/bram_wr_arbiter_if.sv
// Producer-side handshake plus BRAM write port of the arbiter.
// Wires only: no latency, no backpressure.
interface bram_wr_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 32
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]        i_req;
    logic [NUM_REQ-1:0]        i_valid;
    logic [NUM_REQ-1:0]        i_last;
    logic [NUM_REQ*DATA_W-1:0] i_data;
    logic [NUM_REQ-1:0]        o_grant;
    logic [31:0]               bram_addr;
    logic                      ena;
    logic [3:0]                we;
    logic [DATA_W-1:0]         d_out;
    logic                      o_intr;
    logic [ID_W-1:0]           o_intr_src;
    logic                      o_timeout;

    modport slave (
        input  i_req, i_valid, i_last, i_data,
        output o_grant, bram_addr, ena, we, d_out, o_intr, o_intr_src, o_timeout
    );

    modport master (
        output i_req, i_valid, i_last, i_data,
        input  o_grant, bram_addr, ena, we, d_out, o_intr, o_intr_src, o_timeout
    );

endinterface

// File: rtl/bram_wr_arbiter_rr_arbiter.sv
// Round-robin one-hot picker: first set request after last_i, wrapping.
// Combinational, no backpressure.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    last_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    gnt_id_o
);

    int   idx;
    logic found;

    always_comb begin
        gnt_o    = '0;
        gnt_id_o = '0;
        found    = 1'b0;
        idx      = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_i) + k) % NUM_REQ;
            if (!found && req_i[idx]) begin
                found       = 1'b1;
                gnt_o[idx]  = 1'b1;
                gnt_id_o    = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/bram_wr_arbiter.sv
// Burst-granular round-robin share of one BRAM write port; per-requester wrapping regions.
// Latency: 1 cycle beat->write, 1 dead arbitration cycle per grant; no backpressure. Option: BRAM_ARB_TIMEOUT_EN.
module bram_wr_arbiter
    import bram_arb_pkg::*;
#(
    parameter int          NUM_REQ      = 2,
    parameter int          DATA_W       = 32,
    parameter logic [31:0] BASE_ADDR    = 32'h4000_0000,
    parameter int          REGION_WORDS = 64,
    parameter int          MAX_BURST    = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    bram_wr_arbiter_if.slave  bus_io
);

    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PTR_W = (REGION_WORDS > 1) ? $clog2(REGION_WORDS) : 1;

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [ID_W-1:0]    gid_q, gid_d;
    logic [ID_W-1:0]    last_q, last_d;
    logic [PTR_W-1:0]   ptr_q [NUM_REQ];
    logic [PTR_W-1:0]   ptr_d [NUM_REQ];
    logic               ena_q, ena_d;
    logic [3:0]         we_q, we_d;
    logic [31:0]        addr_q, addr_d;
    logic [DATA_W-1:0]  dout_q, dout_d;
    logic               intr_q, intr_d;
    logic [ID_W-1:0]    src_q, src_d;
    logic               tmo_q, tmo_d;

    logic [NUM_REQ-1:0] rr_gnt;
    logic [ID_W-1:0]    rr_id;
    logic               beat;
    logic               cap_hit;

    assign beat = (state_q == GRANT) && bus_io.i_valid[gid_q];

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .req_i    (bus_io.i_req),
        .last_i   (last_q),
        .gnt_o    (rr_gnt),
        .gnt_id_o (rr_id)
    );

`ifdef BRAM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // cnt_q counts beats already written in this grant, so the current beat is the MAX_BURST-th when this holds
    assign cap_hit = (cnt_q == CNT_W'(MAX_BURST - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (beat) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    // Bursts are unbounded; the comparison keeps MAX_BURST referenced and folds to 0.
    assign cap_hit = (MAX_BURST < 0);
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gid_d   = gid_q;
        last_d  = last_q;
        ptr_d   = ptr_q;
        ena_d   = 1'b0;
        we_d    = '0;
        addr_d  = addr_q;
        dout_d  = dout_q;
        intr_d  = 1'b0;
        src_d   = src_q;
        tmo_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (|bus_io.i_req) begin
                    state_d = GRANT;
                    grant_d = rr_gnt;
                    gid_d   = rr_id;
                end
            end
            GRANT: begin
                if (beat) begin
                    ena_d  = 1'b1;
                    we_d   = WE_ALL;
                    dout_d = bus_io.i_data[int'(gid_q)*DATA_W +: DATA_W];
                    addr_d = region_base(BASE_ADDR, 32'(gid_q), REGION_WORDS)
                           + 32'(ptr_q[gid_q]) * 32'(BYTES_PER_WORD);
                    ptr_d[gid_q] = ptr_q[gid_q] + 1'b1;
                    if (bus_io.i_last[gid_q] || cap_hit) begin
                        state_d = IDLE;
                        grant_d = '0;
                        last_d  = gid_q;
                        intr_d  = 1'b1;
                        src_d   = gid_q;
                        tmo_d   = cap_hit && !bus_io.i_last[gid_q];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            gid_q   <= '0;
            last_q  <= ID_W'(NUM_REQ - 1);
            for (int i = 0; i < NUM_REQ; i++) begin
                ptr_q[i] <= '0;
            end
            ena_q   <= 1'b0;
            we_q    <= '0;
            addr_q  <= '0;
            dout_q  <= '0;
            intr_q  <= 1'b0;
            src_q   <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gid_q   <= gid_d;
            last_q  <= last_d;
            for (int i = 0; i < NUM_REQ; i++) begin
                ptr_q[i] <= ptr_d[i];
            end
            ena_q   <= ena_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            intr_q  <= intr_d;
            src_q   <= src_d;
            tmo_q   <= tmo_d;
        end
    end

    assign bus_io.o_grant    = grant_q;
    assign bus_io.bram_addr  = addr_q;
    assign bus_io.ena        = ena_q;
    assign bus_io.we         = we_q;
    assign bus_io.d_out      = dout_q;
    assign bus_io.o_intr     = intr_q;
    assign bus_io.o_intr_src = src_q;
    assign bus_io.o_timeout  = tmo_q;

endmodule

// File: tb/tb_bram_wr_arbiter.sv
// Randomized bench for bram_wr_arbiter against a burst-level reference model.
module tb_bram_wr_arbiter;

    localparam int          NR   = 2;
    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam int          RW   = 64;
    localparam int          MB   = 16;
`ifdef BRAM_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bram_wr_arbiter_if #(.NUM_REQ(NR), .DATA_W(32)) bus ();

    bram_wr_arbiter #(
        .NUM_REQ(NR), .DATA_W(32), .BASE_ADDR(BASE), .REGION_WORDS(RW), .MAX_BURST(MB)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst_n),
        .bus_io (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: who owns the port, who went last, per-region word pointers.
    int          m_owner, m_last, m_cnt;
    int          m_ptr [NR];
    logic [1:0]  e_grant;
    logic        e_ena, e_intr, e_src, e_tmo;
    logic [3:0]  e_we;
    logic [31:0] e_addr, e_dout;

    task automatic model_reset();
        m_owner = -1; m_last = NR - 1; m_cnt = 0;
        for (int i = 0; i < NR; i++) m_ptr[i] = 0;
        e_grant = '0; e_ena = 0; e_we = '0; e_addr = '0; e_dout = '0;
        e_intr = 0; e_src = 0; e_tmo = 0;
    endtask

    task automatic model_step(input logic [1:0] req, input logic [1:0] valid,
                              input logic [1:0] last, input logic [63:0] data);
        int g;
        e_ena = 0; e_we = '0; e_intr = 0; e_tmo = 0;
        if (m_owner < 0) begin
            for (int k = 1; k <= NR; k++) begin
                g = (m_last + k) % NR;
                if (m_owner < 0 && req[g]) m_owner = g;
            end
            if (m_owner >= 0) e_grant = 2'(1 << m_owner);
        end else begin
            g = m_owner;
            if (valid[g]) begin
                e_ena  = 1; e_we = 4'hF;
                e_dout = data[g*32 +: 32];
                e_addr = BASE + 32'(g * RW * 4 + m_ptr[g] * 4);
                m_ptr[g] = (m_ptr[g] + 1) % RW;
                m_cnt++;
                if (last[g] || (TMO_EN && m_cnt == MB)) begin
                    e_intr = 1; e_src = g[0]; e_tmo = !last[g];
                    m_owner = -1; m_last = g; m_cnt = 0; e_grant = '0;
                end
            end
        end
    endtask

    task automatic tick(input logic [1:0] req, input logic [1:0] valid, input logic [1:0] last,
                        input logic [31:0] d0, input logic [31:0] d1);
        bus.i_req = req; bus.i_valid = valid; bus.i_last = last; bus.i_data = {d1, d0};
        @(posedge clk);
        model_step(req, valid, last, {d1, d0});
        #1;
    endtask

    task automatic do_reset();
        bus.i_req = '0; bus.i_valid = '0; bus.i_last = '0; bus.i_data = '0;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #3;
        total++; if (bus.o_grant !== 2'b00) begin bad++; $display("FAIL rst_grant got=%b exp=00", bus.o_grant); end
        total++; if (bus.ena !== 1'b0) begin bad++; $display("FAIL rst_ena got=%b exp=0", bus.ena); end
        total++; if (bus.we !== 4'h0) begin bad++; $display("FAIL rst_we got=%h exp=0", bus.we); end
        total++; if (bus.bram_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", bus.bram_addr); end
        total++; if (bus.d_out !== 32'h0) begin bad++; $display("FAIL rst_dout got=%h exp=0", bus.d_out); end
        total++; if (bus.o_intr !== 1'b0) begin bad++; $display("FAIL rst_intr got=%b exp=0", bus.o_intr); end
        total++; if (bus.o_intr_src !== 1'b0) begin bad++; $display("FAIL rst_src got=%b exp=0", bus.o_intr_src); end
        total++; if (bus.o_timeout !== 1'b0) begin bad++; $display("FAIL rst_tmo got=%b exp=0", bus.o_timeout); end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single_burst();
        tick(2'b01, 2'b00, 2'b00, 32'h0, 32'h0);
        total++; if (bus.o_grant !== 2'b01) begin bad++; $display("FAIL single_grant got=%b exp=01", bus.o_grant); end
        for (int i = 0; i < 5; i++) begin
            if (i < 4) tick(2'b01, 2'b01, (i == 3) ? 2'b01 : 2'b00, 32'(2 * (i + 1)), $urandom);
            else       tick(2'b00, 2'b00, 2'b00, $urandom, $urandom);
            total++;
            if ({bus.o_grant, bus.ena, bus.we, bus.o_intr, bus.o_timeout} !== {e_grant, e_ena, e_we, e_intr, e_tmo}) begin
                bad++; $display("FAIL single_ctl beat=%0d got=%h exp=%h", i,
                    {bus.o_grant, bus.ena, bus.we, bus.o_intr, bus.o_timeout}, {e_grant, e_ena, e_we, e_intr, e_tmo});
            end
            total++;
            if ({bus.bram_addr, bus.d_out, bus.o_intr_src} !== {e_addr, e_dout, e_src}) begin
                bad++; $display("FAIL single_wr beat=%0d got=%h exp=%h", i,
                    {bus.bram_addr, bus.d_out, bus.o_intr_src}, {e_addr, e_dout, e_src});
            end
            if (i < 4) begin
                total++;
                if (bus.bram_addr !== BASE + 32'(4 * i) || bus.d_out !== 32'(2 * (i + 1))) begin
                    bad++; $display("FAIL single_abs beat=%0d got=%h/%h", i, bus.bram_addr, bus.d_out);
                end
            end
        end
        total++; if (bus.o_intr_src !== 1'b0) begin bad++; $display("FAIL single_src got=%b exp=0", bus.o_intr_src); end
    endtask

    task automatic test_contention();
        int         gseq[$];
        int         beats = 0;
        int         ob;
        bit         seen1 = 0;
        logic [1:0] v, l, prev = 2'b00;
        do_reset();
        for (int c = 0; c < 48; c++) begin
            v = 2'($urandom); l = 2'($urandom);
            if (m_owner >= 0) begin
                v[m_owner] = ($urandom_range(3) != 0);
                l[m_owner] = v[m_owner] && (beats == 1);
            end
            ob = m_owner;
            tick(2'b11, v, l, $urandom, $urandom);
            if (ob >= 0 && v[ob]) beats = l[ob] ? 0 : beats + 1;
            total++;
            if ({bus.o_grant, bus.ena, bus.we, bus.o_intr, bus.o_timeout} !== {e_grant, e_ena, e_we, e_intr, e_tmo}) begin
                bad++; $display("FAIL cont_ctl cyc=%0d got=%h exp=%h", c,
                    {bus.o_grant, bus.ena, bus.we, bus.o_intr, bus.o_timeout}, {e_grant, e_ena, e_we, e_intr, e_tmo});
            end
            total++;
            if ({bus.bram_addr, bus.d_out, bus.o_intr_src} !== {e_addr, e_dout, e_src}) begin
                bad++; $display("FAIL cont_wr cyc=%0d got=%h exp=%h", c,
                    {bus.bram_addr, bus.d_out, bus.o_intr_src}, {e_addr, e_dout, e_src});
            end
            if (ob == 1 && v[1] && !seen1) begin
                seen1 = 1;
                total++;
                if (bus.bram_addr !== 32'h4000_0100) begin bad++; $display("FAIL cont_r1_base got=%h exp=40000100", bus.bram_addr); end
            end
            if (prev == 2'b00 && bus.o_grant != 2'b00) gseq.push_back(bus.o_grant == 2'b10 ? 1 : 0);
            prev = bus.o_grant;
        end
        total++; if (gseq.size() < 4) begin bad++; $display("FAIL cont_ngrants got=%0d exp>=4", gseq.size()); end
        foreach (gseq[i]) begin
            total++; if (gseq[i] != i % 2) begin bad++; $display("FAIL cont_order idx=%0d got=%0d exp=%0d", i, gseq[i], i % 2); end
        end
    endtask

    task automatic test_wrap();
        int          nintr = 0;
        logic [31:0] d;
        do_reset();
        for (int b = 0; b < 65; b++) begin
            tick(2'b10, 2'b00, 2'b00, $urandom, $urandom);
            total++;
            if (bus.o_grant !== e_grant || bus.ena !== e_ena) begin
                bad++; $display("FAIL wrap_arb burst=%0d got=%b/%b exp=%b/%b", b, bus.o_grant, bus.ena, e_grant, e_ena);
            end
            d = $urandom;
            tick(2'b10, 2'b10, 2'b10, $urandom, d);
            if (bus.o_intr === 1'b1) nintr++;
            total++;
            if ({bus.o_grant, bus.ena, bus.we, bus.o_intr, bus.o_timeout} !== {e_grant, e_ena, e_we, e_intr, e_tmo}) begin
                bad++; $display("FAIL wrap_ctl burst=%0d got=%h exp=%h", b,
                    {bus.o_grant, bus.ena, bus.we, bus.o_intr, bus.o_timeout}, {e_grant, e_ena, e_we, e_intr, e_tmo});
            end
            total++;
            if ({bus.bram_addr, bus.d_out, bus.o_intr_src} !== {e_addr, d, 1'b1}) begin
                bad++; $display("FAIL wrap_wr burst=%0d got=%h exp=%h", b,
                    {bus.bram_addr, bus.d_out, bus.o_intr_src}, {e_addr, d, 1'b1});
            end
            if (b == 63) begin
                total++; if (bus.bram_addr !== 32'h4000_01FC) begin bad++; $display("FAIL wrap_64th got=%h exp=400001fc", bus.bram_addr); end
            end
            if (b == 64) begin
                total++; if (bus.bram_addr !== 32'h4000_0100) begin bad++; $display("FAIL wrap_65th got=%h exp=40000100", bus.bram_addr); end
            end
        end
        total++; if (nintr != 65) begin bad++; $display("FAIL wrap_nintr got=%0d exp=65", nintr); end
    endtask

    task automatic test_ignored();
        logic [1:0] rq [6] = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
        logic [1:0] vl [6] = '{2'b10, 2'b10, 2'b01, 2'b11, 2'b01, 2'b11};
        logic [1:0] ls [6] = '{2'b10, 2'b10, 2'b00, 2'b10, 2'b01, 2'b11};
        logic [1:0] xg [6] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00};
        logic       xe [6] = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b1,  1'b0};
        tick(2'b00, 2'b11, 2'b11, $urandom, $urandom);
        total++; if (bus.ena !== 1'b0 || bus.o_grant !== 2'b00) begin bad++; $display("FAIL ign_idle got=%b/%b exp=0/00", bus.ena, bus.o_grant); end
        for (int s = 0; s < 6; s++) begin
            tick(rq[s], vl[s], ls[s], $urandom, $urandom);
            total++;
            if (bus.o_grant !== xg[s] || bus.ena !== xe[s]) begin
                bad++; $display("FAIL ign_step step=%0d got=%b/%b exp=%b/%b", s, bus.o_grant, bus.ena, xg[s], xe[s]);
            end
            total++;
            if ({bus.bram_addr, bus.d_out, bus.o_intr, bus.o_intr_src} !== {e_addr, e_dout, e_intr, e_src}) begin
                bad++; $display("FAIL ign_wr step=%0d got=%h exp=%h", s,
                    {bus.bram_addr, bus.d_out, bus.o_intr, bus.o_intr_src}, {e_addr, e_dout, e_intr, e_src});
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [31:0] d;
        tick(2'b01, 2'b00, 2'b00, 32'h0, 32'h0);
        tick(2'b01, 2'b01, 2'b00, $urandom, $urandom);
        tick(2'b01, 2'b01, 2'b00, $urandom, $urandom);
        total++; if (bus.ena !== 1'b1) begin bad++; $display("FAIL mid_pre_ena got=%b exp=1", bus.ena); end
        #2;
        bus.i_req = '0; bus.i_valid = '0; bus.i_last = '0;
        rst_n = 1'b0;
        model_reset();
        #1;
        total++; if (bus.ena !== 1'b0 || bus.we !== 4'h0) begin bad++; $display("FAIL mid_rst_wr got=%b/%h exp=0/0", bus.ena, bus.we); end
        total++; if (bus.o_grant !== 2'b00) begin bad++; $display("FAIL mid_rst_grant got=%b exp=00", bus.o_grant); end
        total++; if (bus.o_intr !== 1'b0) begin bad++; $display("FAIL mid_rst_intr got=%b exp=0", bus.o_intr); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick(2'b01, 2'b00, 2'b00, 32'h0, 32'h0);
        total++; if (bus.o_intr !== e_intr || bus.o_grant !== e_grant) begin bad++; $display("FAIL mid_regrant got=%b/%b exp=%b/%b", bus.o_intr, bus.o_grant, e_intr, e_grant); end
        d = $urandom;
        tick(2'b01, 2'b01, 2'b01, d, $urandom);
        total++; if (bus.bram_addr !== 32'h4000_0000 || bus.d_out !== d) begin bad++; $display("FAIL mid_restart got=%h/%h exp=40000000/%h", bus.bram_addr, bus.d_out, d); end
        total++; if (bus.o_intr !== 1'b1 || bus.ena !== e_ena) begin bad++; $display("FAIL mid_restart_intr got=%b/%b exp=1/%b", bus.o_intr, bus.ena, e_ena); end
    endtask

`ifdef BRAM_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int nwr = 0;
        int ntmo = 0;
        do_reset();
        tick(2'b01, 2'b00, 2'b00, 32'h0, 32'h0);
        for (int b = 0; b < 20; b++) begin
            tick(2'b00, 2'b01, 2'b00, $urandom, $urandom);
            if (bus.ena === 1'b1) nwr++;
            if (bus.o_timeout === 1'b1) ntmo++;
            total++;
            if ({bus.o_grant, bus.ena, bus.we, bus.o_intr, bus.o_timeout} !== {e_grant, e_ena, e_we, e_intr, e_tmo}) begin
                bad++; $display("FAIL tmo_ctl beat=%0d got=%h exp=%h", b,
                    {bus.o_grant, bus.ena, bus.we, bus.o_intr, bus.o_timeout}, {e_grant, e_ena, e_we, e_intr, e_tmo});
            end
            if (b == 15) begin
                total++; if (bus.o_intr !== 1'b1 || bus.o_timeout !== 1'b1) begin bad++; $display("FAIL tmo_pulse got=%b/%b exp=1/1", bus.o_intr, bus.o_timeout); end
            end
        end
        total++; if (nwr != 16) begin bad++; $display("FAIL tmo_nwr got=%0d exp=16", nwr); end
        total++; if (ntmo != 1) begin bad++; $display("FAIL tmo_count got=%0d exp=1", ntmo); end
        total++; if (bus.o_grant !== 2'b00) begin bad++; $display("FAIL tmo_grant got=%b exp=00", bus.o_grant); end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        bus.i_req = '0; bus.i_valid = '0; bus.i_last = '0; bus.i_data = '0;
        model_reset();
        test_reset();
        test_single_burst();
        test_contention();
        test_wrap();
        test_ignored();
        test_reset_mid_burst();
`ifdef BRAM_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        bad++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bram_wr_arbiter.md
Name: bram_wr_arbiter

Overview:
- Shares one PL-side BRAM write port between NUM_REQ streaming PL producers, using round-robin grants at burst granularity.
- Generates the BRAM byte address itself: each requester owns a fixed region of the BRAM with a private, wrapping write pointer.
- Pulses an interrupt to the PS at every burst end and reports which requester finished.
- Sits between the PL producers and the PL port of the dual-port BRAM. The PS reads through the other port.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- DATA_W, 32, BRAM data width; fixed at 32 for we[3:0]
- BASE_ADDR, 32'h4000_0000, byte address of region 0
- REGION_WORDS, 64, words per requester region (power of two)
- MAX_BURST, 16, beat limit per grant; used only with BRAM_ARB_TIMEOUT_EN

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous, active-low reset
- i_req  in  NUM_REQ  per-requester level request
- i_valid  in  NUM_REQ  data beat valid
- i_last  in  NUM_REQ  final beat of burst, qualified by i_valid
- i_data  in  NUM_REQ*DATA_W  packed beat data; requester r uses bits [r*32 +: 32]
- o_grant  out  NUM_REQ  one-hot grant; all zero when idle
- bram_addr  out  32  BRAM byte address
- ena  out  1  BRAM enable
- we  out  4  BRAM byte write enables
- d_out  out  32  BRAM write data
- o_intr  out  1  one-cycle burst-done pulse
- o_intr_src  out  $clog2(NUM_REQ)  requester id of the last completed burst
- o_timeout  out  1  one-cycle forced-release pulse; constant 0 without the macro

Behaviour:
- Reset (i_rst=0, asynchronous): all outputs 0, state IDLE, all write pointers 0, round-robin last-granted index = NUM_REQ-1 (so requester 0 wins first).
- FSM has two states:
  - IDLE: if any i_req is set, grant the first set requester after the last-granted index, wrapping. Register it in o_grant, go to GRANT. Each IDLE cycle is a dead arbitration cycle.
  - GRANT: o_grant is stable. On every cycle with i_valid[g]=1, write one beat. On i_valid[g]&i_last[g]: next cycle o_grant=0, state IDLE, last-granted index=g.
- No backpressure: a granted requester may present a beat every cycle.
- Beat write (registered, 1-cycle latency): the cycle after the beat, ena=1, we=4'hF, d_out=i_data[g], bram_addr = BASE_ADDR + g*REGION_WORDS*4 + ptr[g]*4.
  - The cycle after that: ena=0, we=0, unless another beat follows. bram_addr and d_out hold their last value.
- Pointer: ptr[g] increments per beat, modulo REGION_WORDS. The wrap from REGION_WORDS-1 to 0 is silent and has no effect on the grant.
- Interrupt: o_intr=1 in the same cycle the last beat's write appears on the BRAM port. o_intr_src=g is registered at that point and held until the next completion.
- Ignored inputs and held grants:
  - i_valid or i_last from a non-granted requester, or any input while IDLE, has no effect.
  - i_req dropping during GRANT does not release the grant; only i_last does.
- Reset mid-burst: the burst is discarded immediately. Pointers return to 0 and no o_intr is produced.

Optional Feature:
- Macro BRAM_ARB_TIMEOUT_EN.
- When defined: a beat counter per grant. If the MAX_BURST-th beat is written without i_last, the grant is released exactly as if i_last were set; o_intr and o_timeout both pulse and o_intr_src=g. Further beats from that requester require a new request and grant.
- When not defined: no counter; bursts are unbounded; o_timeout is tied 0.

Decomposition:
- Package bram_arb_pkg holds:
  - FSM state typedef (IDLE, GRANT)
  - WE_ALL=4'hF
  - BYTES_PER_WORD=4
  - a function returning a region's base address from its requester id
- Sub-module rr_arbiter (round-robin one-hot picker: request vector plus last-granted index in, one-hot grant out) is natural and reusable.

Test Plan:
All scenarios use NUM_REQ=2, REGION_WORDS=64, defaults otherwise.
- Single burst: req0, 4 beats 0x2,0x4,0x6,0x8 with last on the 4th -> writes to 0x4000_0000..0x4000_000C with matching d_out and we=F. o_intr pulses with the 4th write; o_intr_src=0.
- Contention: req0 and req1 asserted together, each sending 2-beat bursts, repeated -> grants alternate 0,1,0,1. Requester 1 writes at 0x4000_0100 onward, with one idle cycle between grants.
- Wrap: requester 1 sends 65 single-beat bursts -> the 64th beat lands at 0x4000_01FC and the 65th at 0x4000_0100. o_intr pulses 65 times.
- Ignored inputs: valid from requester 1 while requester 0 is granted produces no write. Dropping req0 mid-burst keeps the grant until last.
- Reset mid-burst: after 2 of 4 beats, pulse i_rst low -> ena/we/o_grant go 0 immediately with no o_intr. The next burst from requester 0 starts at 0x4000_0000.
- Timeout (BRAM_ARB_TIMEOUT_EN, MAX_BURST=16): requester 0 streams 20 beats with no last -> exactly 16 writes, then o_timeout=o_intr=1. Grant drops and the remaining beats are ignored.
